// File: rtl/pla_dly_pkg.sv
// Shared types and constants for the PLA delay-line controller: FSM states,
// serial frame layout and the strap-pin to CAS-tap mapping.
package pla_dly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_PENDING,
    ST_APPLY,
    ST_MEAS
  } state_t;

  localparam int         FRAME_LEN     = 16;
  localparam logic [3:0] FRAME_MAGIC   = 4'hA;
  localparam int         MAGIC_LSB     = 12;
  localparam int         USE_STRAP_BIT = 11;
  localparam int         SPEED_BIT     = 10;
  localparam int         BYPASS_BIT    = 9;
  localparam int         TAP_LSB       = 3;
  localparam int         TAP_W         = 6;
  localparam int         RSVD_W        = 3;

  typedef struct packed {
    logic             bypass;
    logic [TAP_W-1:0] tap;
  } cas_sel_t;

  typedef struct packed {
    logic     useStrap;
    logic     speed;
    cas_sel_t cas;
  } shadow_t;

  // Mirrors the original solder-bridge choices for the CAS delay line.
  function automatic cas_sel_t strapCasMap(input logic [1:0] code);
    cas_sel_t m;
    m.bypass = 1'b0;
    m.tap    = 6'd9;
    case (code)
      2'd1: m.tap = 6'd24;
      2'd2: begin
        m.bypass = 1'b1;
        m.tap    = 6'd0;
      end
      2'd3: m.tap = 6'd39;
      default: m.tap = 6'd9;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with a one-cycle
// pulse on each rising edge of the synchronised level.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pla_delay_ctrl.sv
// Serially configured, CAS-idle-guarded tap selector for the PLA delay lines.
// Define PLA_DLY_MEAS_EN to add the ring-oscillator measurement mode.
module pla_delay_ctrl
  import pla_dly_pkg::*;
#(
  parameter int GUARD_CYCLES = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int TAPS         = 40,
  parameter int MEAS_WIN     = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       strap_speed_i,
  input  logic [1:0] strap_cas_i,
  input  logic       cfg_sclk_i,
  input  logic       cfg_sdata_i,
  input  logic       cfg_latch_i,
  input  logic       casn_i,
  output logic       speed_sel_o,
  output logic       cas_bypass_o,
  output logic [5:0] cas_tap_o,
  output logic       cfg_valid_o,
  output logic       pending_o,
`ifdef PLA_DLY_MEAS_EN
  input  logic        ro_i,
  output logic        ro_en_o,
  output logic [15:0] meas_count_o,
  output logic        meas_done_o,
`endif
  output logic       err_o
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  logic sclkLvl, sclkRise, sdataLvl, sdataRise;
  logic latchLvl, latchRise, casnLvl, casnRise;

  sync_edge #(.STAGES(SYNC_STAGES)) uSyncSclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(cfg_sclk_i), .q_o(sclkLvl), .rise_o(sclkRise));
  sync_edge #(.STAGES(SYNC_STAGES)) uSyncSdata (.clk_i(clk_i), .rst_i(rst_i), .d_i(cfg_sdata_i), .q_o(sdataLvl), .rise_o(sdataRise));
  sync_edge #(.STAGES(SYNC_STAGES)) uSyncLatch (.clk_i(clk_i), .rst_i(rst_i), .d_i(cfg_latch_i), .q_o(latchLvl), .rise_o(latchRise));
  sync_edge #(.STAGES(SYNC_STAGES)) uSyncCasn (.clk_i(clk_i), .rst_i(rst_i), .d_i(casn_i), .q_o(casnLvl), .rise_o(casnRise));

  logic unusedOk;
  assign unusedOk = &{1'b0, sclkLvl, sdataRise, casnRise, (MEAS_WIN > 0)};

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [4:0]           bitCnt_q, bitCnt_d;
  logic [GW-1:0]        guard_q, guard_d;
  shadow_t              shadow_q, shadow_d;
  cas_sel_t             cas_q, cas_d;
  logic                 pending_q, pending_d;
  logic                 err_q, err_d;
  logic                 speed_q, speed_d;
  logic                 cfgValid_q, cfgValid_d;

`ifdef PLA_DLY_MEAS_EN
  localparam int MW = $clog2(MEAS_WIN + 1);
  logic          roLvl, roRise;
  logic [MW-1:0] measWin_q, measWin_d;
  logic [15:0]   measCnt_q, measCnt_d;
  logic          measDone_q, measDone_d;
  logic          unusedRo;

  sync_edge #(.STAGES(SYNC_STAGES)) uSyncRo (.clk_i(clk_i), .rst_i(rst_i), .d_i(ro_i), .q_o(roLvl), .rise_o(roRise));
  assign unusedRo = roLvl;
`endif

  logic             shiftEn, frameStart, magicOk, rsvdOk, tapOk, frameValid;
  logic [TAP_W-1:0] frameTap;

  assign shiftEn    = (state_q != ST_CHECK) && sclkRise && !latchLvl;
  assign frameStart = latchRise && (bitCnt_q != 5'd0);
  assign frameTap   = shift_q[TAP_LSB +: TAP_W];
  assign magicOk    = shift_q[MAGIC_LSB +: 4] == FRAME_MAGIC;
  assign tapOk      = shift_q[BYPASS_BIT] || (frameTap <= TAP_W'(TAPS - 1));
`ifdef PLA_DLY_MEAS_EN
  // Bit 0 requests a measurement instead of being reserved.
  assign rsvdOk     = shift_q[RSVD_W-1:1] == '0;
`else
  assign rsvdOk     = shift_q[RSVD_W-1:0] == '0;
`endif
  assign frameValid = (bitCnt_q == 5'(FRAME_LEN)) && magicOk && rsvdOk && tapOk;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitCnt_d   = bitCnt_q;
    guard_d    = guard_q;
    shadow_d   = shadow_q;
    cas_d      = cas_q;
    pending_d  = pending_q;
    err_d      = err_q;
    speed_d    = speed_q;
    cfgValid_d = cfgValid_q;
`ifdef PLA_DLY_MEAS_EN
    measWin_d  = measWin_q;
    measCnt_d  = measCnt_q;
    measDone_d = 1'b0;
`endif

    // The shifter runs alongside the FSM so a new frame can arrive while pending.
    if (shiftEn) begin
      shift_d = {shift_q[FRAME_LEN-2:0], sdataLvl};
      if (bitCnt_q != 5'(FRAME_LEN + 1)) bitCnt_d = bitCnt_q + 5'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frameStart) state_d = ST_CHECK;
        else if (shiftEn) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (frameStart) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        shift_d  = '0;
        bitCnt_d = '0;
        if (frameValid) begin
          err_d = 1'b0;
`ifdef PLA_DLY_MEAS_EN
          if (shift_q[0]) begin
            measWin_d = '0;
            measCnt_d = '0;
            state_d   = ST_MEAS;
          end else begin
`else
          begin
`endif
            shadow_d.useStrap   = shift_q[USE_STRAP_BIT];
            shadow_d.speed      = shift_q[SPEED_BIT];
            shadow_d.cas.bypass = shift_q[BYPASS_BIT];
            shadow_d.cas.tap    = frameTap;
            pending_d           = 1'b1;
            guard_d             = '0;
            state_d             = ST_PENDING;
          end
        end else begin
          err_d   = 1'b1;
          state_d = pending_q ? ST_PENDING : ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (frameStart) begin
          state_d = ST_CHECK;
        end else if (!casnLvl) begin
          guard_d = '0;
        end else if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          // Outputs switch on entry to APPLY so CAS has been idle for the full window.
          guard_d   = '0;
          pending_d = 1'b0;
          state_d   = ST_APPLY;
          if (shadow_q.useStrap) begin
            cas_d      = strapCasMap(strap_cas_i);
            speed_d    = strap_speed_i;
            cfgValid_d = 1'b0;
          end else begin
            cas_d      = shadow_q.cas;
            speed_d    = shadow_q.speed;
            cfgValid_d = 1'b1;
          end
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_APPLY: begin
        state_d = frameStart ? ST_CHECK : ST_IDLE;
      end
`ifdef PLA_DLY_MEAS_EN
      ST_MEAS: begin
        measWin_d = measWin_q + 1'b1;
        if (roRise && (measCnt_q != 16'hFFFF)) measCnt_d = measCnt_q + 16'd1;
        if (measWin_q == MW'(MEAS_WIN - 1)) begin
          measDone_d = 1'b1;
          state_d    = pending_q ? ST_PENDING : ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      guard_q    <= '0;
      shadow_q   <= '0;
      cas_q      <= strapCasMap(strap_cas_i);
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      speed_q    <= strap_speed_i;
      cfgValid_q <= 1'b0;
`ifdef PLA_DLY_MEAS_EN
      measWin_q  <= '0;
      measCnt_q  <= '0;
      measDone_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitCnt_q   <= bitCnt_d;
      guard_q    <= guard_d;
      shadow_q   <= shadow_d;
      cas_q      <= cas_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      speed_q    <= speed_d;
      cfgValid_q <= cfgValid_d;
`ifdef PLA_DLY_MEAS_EN
      measWin_q  <= measWin_d;
      measCnt_q  <= measCnt_d;
      measDone_q <= measDone_d;
`endif
    end
  end

  assign speed_sel_o  = speed_q;
  assign cas_bypass_o = cas_q.bypass;
  assign cas_tap_o    = cas_q.tap;
  assign cfg_valid_o  = cfgValid_q;
  assign pending_o    = pending_q;
  assign err_o        = err_q;
`ifdef PLA_DLY_MEAS_EN
  assign ro_en_o      = state_q == ST_MEAS;
  assign meas_count_o = measCnt_q;
  assign meas_done_o  = measDone_q;
`endif

endmodule
